// File: rtl/uart_receiver_if.sv
// Serial-line bundle between the pin-side stimulus/source and the UART receiver.
interface uart_receiver_if;
  logic       i_rx;
  logic [0:7] o_data;
  logic       o_valid;
  logic       o_framing_error;
  logic       o_busy;

  modport master (
    output i_rx,
    input  o_data, o_valid, o_framing_error, o_busy
  );

  modport slave (
    input  i_rx,
    output o_data, o_valid, o_framing_error, o_busy
  );
endinterface

// File: rtl/uart_receiver.sv
// 8N1 UART receiver: synchronizes the line, finds the start edge and samples at bit centres.
// Optional build macro UART_RX_MAJORITY_VOTE_EN: 2-of-3 majority over the last three s2 values.
module uart_receiver #(
  parameter int unsigned BAUD_RATE         = 10000,
  parameter int unsigned CLOCK_FREQUENCY   = 100000000,
  parameter int unsigned CYCLES_PER_SAMPLE = CLOCK_FREQUENCY / BAUD_RATE
) (
  input  logic            clk,
  input  logic            i_reset_n,
  uart_receiver_if.slave  rx_if
);

  localparam int unsigned CNT_W = 16;
  localparam int unsigned HALF  = CYCLES_PER_SAMPLE / 2;
  localparam logic [CNT_W-1:0] HALF_M1 = CNT_W'(HALF - 1);
  localparam logic [CNT_W-1:0] LAST    = CNT_W'(CYCLES_PER_SAMPLE - 1);

  typedef enum logic [1:0] {IDLE, START, DATA, STOP} state_t;

  state_t           state;
  logic [CNT_W-1:0] cycle_count;
  logic [2:0]       bit_idx;
  logic [0:7]       shift;
  logic [0:7]       data_q;
  logic             valid_q;
  logic             ferr_q;
  logic             busy_q;
  logic             s1, s2, s_prev;
  logic             sample;

`ifdef UART_RX_MAJORITY_VOTE_EN
  logic s_prev2;

  // s_prev2 only feeds the vote; it shares the synchronizer's idle-high reset
  always_ff @(posedge clk or negedge i_reset_n) begin
    if (!i_reset_n) s_prev2 <= 1'b1;
    else            s_prev2 <= s_prev;
  end

  assign sample = (s2 & s_prev) | (s2 & s_prev2) | (s_prev & s_prev2);
`else
  assign sample = s2;
`endif

  always_ff @(posedge clk or negedge i_reset_n) begin
    if (!i_reset_n) begin
      s1          <= 1'b1;
      s2          <= 1'b1;
      s_prev      <= 1'b1;
      state       <= IDLE;
      cycle_count <= '0;
      bit_idx     <= '0;
      shift       <= '0;
      data_q      <= '0;
      valid_q     <= 1'b0;
      ferr_q      <= 1'b0;
      busy_q      <= 1'b0;
    end else begin
      s1      <= rx_if.i_rx;
      s2      <= s1;
      s_prev  <= s2;
      valid_q <= 1'b0;
      ferr_q  <= 1'b0;
      case (state)
        IDLE: begin
          cycle_count <= '0;
          if (s_prev && !s2) begin
            state  <= START;
            busy_q <= 1'b1;
          end
        end
        START: begin
          if (cycle_count == HALF_M1) begin
            cycle_count <= '0;
            bit_idx     <= '0;
            if (!sample) begin
              state <= DATA;
            end else begin
              state  <= IDLE;
              busy_q <= 1'b0;
            end
          end else begin
            cycle_count <= cycle_count + CNT_W'(1);
          end
        end
        DATA: begin
          if (cycle_count == LAST) begin
            shift[bit_idx] <= sample;
            cycle_count    <= '0;
            bit_idx        <= bit_idx + 3'd1;
            if (bit_idx == 3'd7) state <= STOP;
          end else begin
            cycle_count <= cycle_count + CNT_W'(1);
          end
        end
        STOP: begin
          // Leave at the stop centre so a back-to-back start edge is not missed
          if (cycle_count == LAST) begin
            if (sample) begin
              data_q  <= shift;
              valid_q <= 1'b1;
            end else begin
              ferr_q  <= 1'b1;
            end
            state       <= IDLE;
            busy_q      <= 1'b0;
            cycle_count <= '0;
          end else begin
            cycle_count <= cycle_count + CNT_W'(1);
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

  assign rx_if.o_data          = data_q;
  assign rx_if.o_valid         = valid_q;
  assign rx_if.o_framing_error = ferr_q;
  assign rx_if.o_busy          = busy_q;

endmodule
